// File: rtl/fpu_op_sequencer.sv
// Issue/collect stage around the combinational FP adder: request FIFO, settle-timed execution, response register, sticky flags.
// Optional op counter output o_op_cnt enabled by defining FPU_OP_COUNT_EN.
module fpu_op_sequencer #(
    parameter int DEPTH      = 4,
    parameter int SETTLE_CYC = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_req_a,
    input  logic [31:0] i_req_b,
    input  logic        i_req_sub,
    output logic [31:0] o_fpu_a,
    output logic [31:0] o_fpu_b,
    output logic        o_fpu_add_sub,
    input  logic [31:0] i_fpu_s,
    input  logic        i_fpu_ov,
    input  logic        i_fpu_un,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_s,
    output logic        o_rsp_ov,
    output logic        o_rsp_un,
    output logic        o_sticky_ov,
    output logic        o_sticky_un,
    input  logic        i_sticky_clr,
`ifdef FPU_OP_COUNT_EN
    output logic [15:0] o_op_cnt,
`endif
    output logic        o_busy
);

    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [PW:0]     FULL_CNT    = (PW + 1)'(DEPTH);
    localparam logic [CNTW-1:0] SETTLE_LOAD = CNTW'(SETTLE_CYC - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [64:0]     mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW:0]     count_q, count_d;
    logic            push;
    logic            pop;
    logic            fifo_empty;
    logic [64:0]     head;

    logic [1:0]      state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [31:0]     fpu_a_q, fpu_a_d;
    logic [31:0]     fpu_b_q, fpu_b_d;
    logic            fpu_sub_q, fpu_sub_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [31:0]     rsp_s_q, rsp_s_d;
    logic            rsp_ov_q, rsp_ov_d;
    logic            rsp_un_q, rsp_un_d;
    logic            sticky_ov_q, sticky_ov_d;
    logic            sticky_un_q, sticky_un_d;
    logic            capture;

    // Ready depends on occupancy only, so a full FIFO refuses even when a pop happens this cycle.
    assign o_req_ready = (count_q != FULL_CNT);
    assign push        = i_req_valid && o_req_ready;
    assign fifo_empty  = (count_q == '0);
    assign head        = mem_q[rd_ptr_q];

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {i_req_sub, i_req_b, i_req_a};
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fpu_a_d     = fpu_a_q;
        fpu_b_d     = fpu_b_q;
        fpu_sub_d   = fpu_sub_q;
        rsp_valid_d = rsp_valid_q;
        rsp_s_d     = rsp_s_q;
        rsp_ov_d    = rsp_ov_q;
        rsp_un_d    = rsp_un_q;
        pop         = 1'b0;
        capture     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                end
            end
            ST_EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    capture     = 1'b1;
                    rsp_s_d     = i_fpu_s;
                    rsp_ov_d    = i_fpu_ov;
                    rsp_un_d    = i_fpu_un;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Both IDLE and RESP-handshake issue share the same load path.
        if (pop) begin
            fpu_a_d   = head[31:0];
            fpu_b_d   = head[63:32];
            fpu_sub_d = head[64];
            cnt_d     = SETTLE_LOAD;
            state_d   = ST_EXEC;
        end
    end

    // Set takes priority over clear when both land on the same edge.
    always_comb begin
        sticky_ov_d = (sticky_ov_q && !i_sticky_clr) || (capture && i_fpu_ov);
        sticky_un_d = (sticky_un_q && !i_sticky_clr) || (capture && i_fpu_un);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            fpu_a_q     <= '0;
            fpu_b_q     <= '0;
            fpu_sub_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_s_q     <= '0;
            rsp_ov_q    <= 1'b0;
            rsp_un_q    <= 1'b0;
            sticky_ov_q <= 1'b0;
            sticky_un_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fpu_a_q     <= fpu_a_d;
            fpu_b_q     <= fpu_b_d;
            fpu_sub_q   <= fpu_sub_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_s_q     <= rsp_s_d;
            rsp_ov_q    <= rsp_ov_d;
            rsp_un_q    <= rsp_un_d;
            sticky_ov_q <= sticky_ov_d;
            sticky_un_q <= sticky_un_d;
        end
    end

`ifdef FPU_OP_COUNT_EN
    logic [15:0] op_cnt_q, op_cnt_d;

    always_comb begin
        op_cnt_d = op_cnt_q;
        if (i_sticky_clr) begin
            op_cnt_d = '0;
        end else if (rsp_valid_q && i_rsp_ready && (op_cnt_q != '1)) begin
            op_cnt_d = op_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            op_cnt_q <= '0;
        end else begin
            op_cnt_q <= op_cnt_d;
        end
    end

    assign o_op_cnt = op_cnt_q;
`endif

    assign o_fpu_a       = fpu_a_q;
    assign o_fpu_b       = fpu_b_q;
    assign o_fpu_add_sub = fpu_sub_q;
    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_s       = rsp_s_q;
    assign o_rsp_ov      = rsp_ov_q;
    assign o_rsp_un      = rsp_un_q;
    assign o_sticky_ov   = sticky_ov_q;
    assign o_sticky_un   = sticky_un_q;
    assign o_busy        = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Directed bench for fpu_op_sequencer with a table-driven adder stand-in; exercises o_op_cnt when FPU_OP_COUNT_EN is defined.
module tb_fpu_op_sequencer;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        req_sub;
    logic [31:0] fpu_a;
    logic [31:0] fpu_b;
    logic        fpu_add_sub;
    logic [31:0] fpu_s;
    logic        fpu_ov;
    logic        fpu_un;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_s;
    logic        rsp_ov;
    logic        rsp_un;
    logic        sticky_ov;
    logic        sticky_un;
    logic        sticky_clr;
    logic        busy;
`ifdef FPU_OP_COUNT_EN
    logic [15:0] op_cnt;
`endif

    int unsigned n_total;
    int unsigned n_pass;

    fpu_op_sequencer #(
        .DEPTH      (4),
        .SETTLE_CYC (2)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_a       (req_a),
        .i_req_b       (req_b),
        .i_req_sub     (req_sub),
        .o_fpu_a       (fpu_a),
        .o_fpu_b       (fpu_b),
        .o_fpu_add_sub (fpu_add_sub),
        .i_fpu_s       (fpu_s),
        .i_fpu_ov      (fpu_ov),
        .i_fpu_un      (fpu_un),
        .o_rsp_valid   (rsp_valid),
        .i_rsp_ready   (rsp_ready),
        .o_rsp_s       (rsp_s),
        .o_rsp_ov      (rsp_ov),
        .o_rsp_un      (rsp_un),
        .o_sticky_ov   (sticky_ov),
        .o_sticky_un   (sticky_un),
        .i_sticky_clr  (sticky_clr),
`ifdef FPU_OP_COUNT_EN
        .o_op_cnt      (op_cnt),
`endif
        .o_busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Adder stand-in: known IEEE vectors from a table, otherwise integer a+b+sub as a traceable tag.
    always_comb begin
        fpu_ov = 1'b0;
        fpu_un = 1'b0;
        fpu_s  = fpu_a + fpu_b + {31'd0, fpu_add_sub};
        if (fpu_a == 32'h41E00000 && fpu_b == 32'h40700000 && !fpu_add_sub) begin
            fpu_s = 32'h41FE0000;
        end else if (fpu_a == 32'h3F400000 && fpu_b == 32'h41320000 && fpu_add_sub) begin
            fpu_s = 32'hC1260000;
        end else if (fpu_a == 32'h7F800000 && fpu_b == 32'h41320000 && !fpu_add_sub) begin
            fpu_s  = 32'h7F800000;
            fpu_ov = 1'b1;
        end else if (fpu_a == 32'h00800001 && fpu_b == 32'h00800000 && fpu_add_sub) begin
            fpu_s  = 32'h00000000;
            fpu_un = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic sub);
        int unsigned waited;
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_sub   = sub;
        waited    = 0;
        while (!req_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (!req_ready) begin
            check("push_ready_timeout", {31'd0, req_ready}, 32'd1);
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag);
        int unsigned waited;
        waited = 0;
        while (!rsp_valid && waited < 20) begin
            tick();
            waited++;
        end
        check(tag, {31'd0, rsp_valid}, 32'd1);
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        n_total    = 0;
        n_pass     = 0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_a      = '0;
        req_b      = '0;
        req_sub    = 1'b0;
        rsp_ready  = 1'b0;
        sticky_clr = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_fpu_a", fpu_a, 32'd0);
        check("rst_rsp_s", rsp_s, 32'd0);
        check("rst_sticky_ov", {31'd0, sticky_ov}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Single add: valid rises three edges after acceptance.
        req_valid = 1'b1;
        req_a     = 32'h41E00000;
        req_b     = 32'h40700000;
        req_sub   = 1'b0;
        tick();
        req_valid = 1'b0;
        check("t1_busy_after_accept", {31'd0, busy}, 32'd1);
        tick();
        check("t1_fpu_a_popped", fpu_a, 32'h41E00000);
        check("t1_fpu_b_popped", fpu_b, 32'h40700000);
        check("t1_valid_n1", {31'd0, rsp_valid}, 32'd0);
        tick();
        check("t1_valid_n2", {31'd0, rsp_valid}, 32'd0);
        tick();
        check("t1_valid_n3", {31'd0, rsp_valid}, 32'd1);
        check("t1_sum", rsp_s, 32'h41FE0000);
        check("t1_ov", {31'd0, rsp_ov}, 32'd0);
        check("t1_un", {31'd0, rsp_un}, 32'd0);
        handshake();
        check("t1_valid_cleared", {31'd0, rsp_valid}, 32'd0);
        check("t1_idle", {31'd0, busy}, 32'd0);
        check("t1_fpu_a_held", fpu_a, 32'h41E00000);

        // Backpressure: five accepted, sixth refused, results in push order.
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1;
            req_a     = 32'h10000000 + i;
            req_b     = i;
            req_sub   = 1'b0;
            check($sformatf("t2_ready_%0d", i), {31'd0, req_ready}, 32'd1);
            tick();
        end
        check("t2_ready_full", {31'd0, req_ready}, 32'd0);
        req_a = 32'hDEAD0000;
        tick();
        req_valid = 1'b0;
        wait_rsp("t2_first_valid");
        check("t2_first_s", rsp_s, 32'h10000000);
        repeat (3) tick();
        check("t2_s_stable", rsp_s, 32'h10000000);
        check("t2_ready_still_full", {31'd0, req_ready}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            wait_rsp($sformatf("t2_valid_%0d", i));
            check($sformatf("t2_s_%0d", i), rsp_s, 32'h10000000 + 2 * i);
            handshake();
        end
        check("t2_drained", {31'd0, busy}, 32'd0);

        // Subtract followed by back-to-back issue on the handshake edge.
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_a     = 32'h3F400000;
        req_b     = 32'h41320000;
        req_sub   = 1'b1;
        tick();
        req_a   = 32'h00000010;
        req_b   = 32'h00000020;
        req_sub = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        check("t3_valid", {31'd0, rsp_valid}, 32'd1);
        check("t3_diff", rsp_s, 32'hC1260000);
        tick();
        check("t3_valid_low", {31'd0, rsp_valid}, 32'd0);
        check("t3_second_popped", fpu_a, 32'h00000010);
        check("t3_second_sub", {31'd0, fpu_add_sub}, 32'd0);
        tick();
        tick();
        check("t3_second_valid", {31'd0, rsp_valid}, 32'd1);
        check("t3_second_s", rsp_s, 32'h00000030);
        tick();
        rsp_ready = 1'b0;
        check("t3_idle", {31'd0, busy}, 32'd0);

        // Sticky flags.
        push(32'h7F800000, 32'h41320000, 1'b0);
        wait_rsp("t4_inf_valid");
        check("t4_rsp_ov", {31'd0, rsp_ov}, 32'd1);
        check("t4_sticky_ov", {31'd0, sticky_ov}, 32'd1);
        handshake();
        push(32'h00000001, 32'h00000002, 1'b0);
        wait_rsp("t4_clean_valid");
        check("t4_clean_ov", {31'd0, rsp_ov}, 32'd0);
        check("t4_sticky_kept", {31'd0, sticky_ov}, 32'd1);
        handshake();
        push(32'h00800001, 32'h00800000, 1'b1);
        wait_rsp("t4_un_valid");
        check("t4_rsp_un", {31'd0, rsp_un}, 32'd1);
        check("t4_sticky_un", {31'd0, sticky_un}, 32'd1);
        handshake();
        sticky_clr = 1'b1;
        tick();
        sticky_clr = 1'b0;
        check("t4_clr_ov", {31'd0, sticky_ov}, 32'd0);
        check("t4_clr_un", {31'd0, sticky_un}, 32'd0);
        push(32'h7F800000, 32'h41320000, 1'b0);
        tick();
        tick();
        sticky_clr = 1'b1;
        tick();
        sticky_clr = 1'b0;
        check("t4_set_wins_valid", {31'd0, rsp_valid}, 32'd1);
        check("t4_set_wins", {31'd0, sticky_ov}, 32'd1);
        handshake();

        // Asynchronous reset while executing with requests queued.
        push(32'h00000100, 32'h00000001, 1'b0);
        push(32'h00000200, 32'h00000001, 1'b0);
        push(32'h00000300, 32'h00000001, 1'b0);
        check("t5_busy_before", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        check("t5_rst_ready", {31'd0, req_ready}, 32'd1);
        check("t5_rst_sticky", {31'd0, sticky_ov}, 32'd0);
        check("t5_rst_fpu_a", fpu_a, 32'd0);
        #5 rst_n = 1'b1;
        @(negedge clk);
        repeat (8) tick();
        check("t5_no_stale_valid", {31'd0, rsp_valid}, 32'd0);
        check("t5_no_stale_busy", {31'd0, busy}, 32'd0);

`ifdef FPU_OP_COUNT_EN
        check("t6_cnt_reset", {16'd0, op_cnt}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            push(32'h00000040 + i, 32'h00000001, 1'b0);
            wait_rsp($sformatf("t6_valid_%0d", i));
            handshake();
        end
        check("t6_cnt_10", {16'd0, op_cnt}, 32'd10);
        sticky_clr = 1'b1;
        tick();
        sticky_clr = 1'b0;
        check("t6_cnt_clr", {16'd0, op_cnt}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
